// File: rtl/wb_ram_dp_pkg.sv
// wb_ram_dp_pkg: FSM states and elaboration helpers shared by the dual-port Wishbone RAM
package wb_ram_dp_pkg;
  localparam int ADDR_W = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/wb_ram_dp_if.sv
// wb_ram_dp_if: Wishbone classic bundle for one RAM port
interface wb_ram_dp_if #(parameter int DW = 32);
  logic [31:0] addr;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] sel;
  logic we;
  logic cyc;
  logic stb;
  logic [DW-1:0] rdata;
  logic ack;
  logic err;
  modport master(output addr, wdata, sel, we, cyc, stb, input rdata, ack, err);
  modport slave(input addr, wdata, sel, we, cyc, stb, output rdata, ack, err);
endinterface

// File: rtl/wb_ram_dp_port.sv
// wb_ram_dp_port: one Wishbone port sequencer with wait states, error decode and registered response
module wb_ram_dp_port
  import wb_ram_dp_pkg::*;
#(
  parameter int DW = 32,
  parameter int DEPTH = 4096,
  parameter int WAIT = 0,
  localparam int SW = lanes(DW),
  localparam int AW = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cyc,
  input  logic              stb,
  input  logic              we,
  input  logic [DW-1:0]     mem_rdata,
  output logic [AW-1:0]     idx,
  output logic              wr,
  output logic [DW-1:0]     rdata,
  output logic              ack,
  output logic              err
);
  localparam int SB = clog2(SW);
  localparam logic [3:0] LAST = WAIT == 0 ? 4'd0 : 4'(WAIT - 1);
  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'(SW);
  state_t state;
  logic [3:0] cnt;
  logic req, bad, go;
  // go marks the edge that enters RESP; address, data and write commit are all sampled there
  always_comb begin
    req = cyc & stb;
    bad = (addr & ADDR_W'(SW - 1)) != '0 || 64'(addr) >= LIMIT;
    go = req & (state == ST_IDLE ? WAIT == 0 : state == ST_WAIT && cnt == LAST);
    idx = addr[SB +: AW];
    wr = go & we & ~bad & ~reset;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      ack <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state == ST_IDLE ? (req ? (WAIT == 0 ? ST_RESP : ST_WAIT) : ST_IDLE)
             : state == ST_WAIT ? (!req ? ST_IDLE : go ? ST_RESP : ST_WAIT) : ST_IDLE;
      cnt <= state == ST_WAIT ? cnt + 4'd1 : 4'd0;
      ack <= go & ~bad;
      err <= go & bad;
      rdata <= go & ~bad ? mem_rdata : '0;
    end
  end
endmodule

// File: rtl/wb_ram_dp.sv
// wb_ram_dp: dual-port Wishbone classic RAM, read-only fetch port I and load/store port D on one array
module wb_ram_dp
  import wb_ram_dp_pkg::*;
#(
  parameter int DW = 32,
  parameter int DEPTH = 4096,
  parameter int WAIT = 0,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  wb_ram_dp_if.slave  i_bus,
  wb_ram_dp_if.slave  d_bus
);
  localparam int SW = lanes(DW);
  localparam int AW = clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH-1:0];
  logic [AW-1:0] i_idx, d_idx;
  logic i_wr_unused, d_wr;
  wb_ram_dp_port #(.DW(DW), .DEPTH(DEPTH), .WAIT(WAIT)) u_i (
    .clk(clk), .reset(reset), .addr(i_bus.addr), .cyc(i_bus.cyc), .stb(i_bus.stb), .we(1'b0),
    .mem_rdata(mem[i_idx]), .idx(i_idx), .wr(i_wr_unused),
    .rdata(i_bus.rdata), .ack(i_bus.ack), .err(i_bus.err)
  );
  wb_ram_dp_port #(.DW(DW), .DEPTH(DEPTH), .WAIT(WAIT)) u_d (
    .clk(clk), .reset(reset), .addr(d_bus.addr), .cyc(d_bus.cyc), .stb(d_bus.stb), .we(d_bus.we),
    .mem_rdata(mem[d_idx]), .idx(d_idx), .wr(d_wr),
    .rdata(d_bus.rdata), .ack(d_bus.ack), .err(d_bus.err)
  );
  always_ff @(posedge clk) begin
    for (int b = 0; b < SW; b++)
      if (d_wr && d_bus.sel[b]) mem[d_idx][b*8 +: 8] <= d_bus.wdata[b*8 +: 8];
  end
endmodule
